vscale_pc_gen: RTL and testbench

//  Next-PC generator for the IF stage: next-PC mux plus the PC_IF register.

---
 rtl/vscale_pc_gen_pkg.sv | 34 +++
 rtl/vscale_pc_gen_if.sv | 37 +++
 rtl/vscale_ras.sv | 71 +++++++
 rtl/vscale_pc_gen.sv | 110 +++++++++++
 tb/tb_vscale_pc_gen.sv | 326 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vscale_pc_gen_pkg.sv
// Shared types and constants for the IF-stage next-PC generator and its return-address stack.
package vscale_pc_gen_pkg;

  localparam int unsigned PC_SRC_SEL_WIDTH = 3;

  // Ctrl encoding of the next-PC source; PcRasPred occupies the last free code.
  typedef enum logic [PC_SRC_SEL_WIDTH-1:0] {
    PcPlusFour     = 3'd0,
    PcBranchTarget = 3'd1,
    PcJalTarget    = 3'd2,
    PcJalrTarget   = 3'd3,
    PcReplay       = 3'd4,
    PcHandler      = 3'd5,
    PcEpc          = 3'd6,
    PcRasPred      = 3'd7
  } pc_src_sel_e;

  typedef enum logic [1:0] {
    RasNone,
    RasPush,
    RasPop,
    RasReplace
  } ras_op_e;

  localparam logic [6:0] OPCODE_JAL  = 7'b1101111;
  localparam logic [6:0] OPCODE_JALR = 7'b1100111;
  localparam logic [4:0] RA_X1       = 5'd1;
  localparam logic [4:0] RA_X5       = 5'd5;

  function automatic logic is_link(input logic [4:0] reg_idx);
    return (reg_idx == RA_X1) || (reg_idx == RA_X5);
  endfunction

endpackage

// File: rtl/vscale_pc_gen_if.sv
// Ctrl/datapath-facing bundle of the next-PC generator; slave is the generator itself.
interface vscale_pc_gen_if
  import vscale_pc_gen_pkg::*;
#(
  parameter int unsigned XPR_LEN = 32
) ();

  logic                stall_if;
  pc_src_sel_e         pc_src_sel;
  logic [31:0]         inst_dx;
  logic                ras_update_en;
  logic [XPR_LEN-1:0]  rs1_data;
  logic [XPR_LEN-1:0]  pc_dx;
  logic [XPR_LEN-1:0]  handler_pc;
  logic [XPR_LEN-1:0]  epc;

  logic [XPR_LEN-1:0]  pc_pif;
  logic [XPR_LEN-1:0]  pc_if;
  logic                redirect_pending;
  logic                target_misaligned;
  logic [XPR_LEN-1:0]  ras_top;
  logic                ras_valid;
  logic                ras_underflow;

  modport master (
    output stall_if, pc_src_sel, inst_dx, ras_update_en, rs1_data, pc_dx, handler_pc, epc,
    input  pc_pif, pc_if, redirect_pending, target_misaligned, ras_top, ras_valid,
           ras_underflow
  );

  modport slave (
    input  stall_if, pc_src_sel, inst_dx, ras_update_en, rs1_data, pc_dx, handler_pc, epc,
    output pc_pif, pc_if, redirect_pending, target_misaligned, ras_top, ras_valid,
           ras_underflow
  );

endinterface

// File: rtl/vscale_ras.sv
// Circular return-address stack: push overwrites the oldest entry when full, pop on empty
// only raises a one-cycle underflow pulse.
module vscale_ras
  import vscale_pc_gen_pkg::*;
#(
  parameter int unsigned XPR_LEN   = 32,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  ras_op_e            i_op,
  input  logic [XPR_LEN-1:0] i_push_data,
  output logic [XPR_LEN-1:0] o_top,
  output logic               o_valid,
  output logic               o_underflow
);

  localparam int unsigned PtrW = $clog2(RAS_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [XPR_LEN-1:0] r_stack [RAS_DEPTH];
  logic [PtrW-1:0]    r_ptr;
  logic [CntW-1:0]    r_count;
  logic               r_underflow;

  logic [PtrW-1:0]    w_top_idx;
  logic               w_empty;
  logic               w_full;
  logic               w_push;
  logic               w_replace;

  assign w_top_idx = r_ptr - PtrW'(1);
  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == CntW'(RAS_DEPTH));
  // Replace on an empty stack degenerates to a plain push.
  assign w_push    = (i_op == RasPush) || ((i_op == RasReplace) && w_empty);
  assign w_replace = (i_op == RasReplace) && !w_empty;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_ptr       <= '0;
      r_count     <= '0;
      r_underflow <= 1'b0;
    end else begin
      r_underflow <= 1'b0;
      if (w_push) begin
        r_ptr <= r_ptr + PtrW'(1);
        if (!w_full) r_count <= r_count + CntW'(1);
      end else if (i_op == RasPop) begin
        if (w_empty) begin
          r_underflow <= 1'b1;
        end else begin
          r_ptr   <= w_top_idx;
          r_count <= r_count - CntW'(1);
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset_n) begin
      if (w_push)         r_stack[r_ptr]     <= i_push_data;
      else if (w_replace) r_stack[w_top_idx] <= i_push_data;
    end
  end

  assign o_top       = w_empty ? '0 : r_stack[w_top_idx];
  assign o_valid     = !w_empty;
  assign o_underflow = r_underflow;

endmodule

// File: rtl/vscale_pc_gen.sv
// IF-stage next-PC generator: target mux, held redirect across fetch stalls, PC_IF register,
// JALR bit-0 clear with alignment flag, and RAS-based return prediction.
module vscale_pc_gen
  import vscale_pc_gen_pkg::*;
#(
  parameter int unsigned        XPR_LEN   = 32,
  parameter logic [XPR_LEN-1:0] RESET_PC  = 'h200,
  parameter int unsigned        RAS_DEPTH = 4,
  parameter int unsigned        IALIGN    = 32
) (
  input logic           i_clk,
  input logic           i_reset_n,
  vscale_pc_gen_if.slave bus
);

  logic [XPR_LEN-1:0] r_pc_if;
  logic [XPR_LEN-1:0] r_pend_pc;
  logic               r_pending;

  logic [XPR_LEN-1:0] w_imm_i, w_imm_b, w_imm_j;
  logic [XPR_LEN-1:0] w_jalr_sum;
  logic [XPR_LEN-1:0] w_mux_pc;
  logic [XPR_LEN-1:0] w_pc_pif;
  logic [XPR_LEN-1:0] w_ras_top;
  logic               w_redirect;
  logic [4:0]         w_rd, w_rs1;
  logic [6:0]         w_opcode;
  logic               w_rd_link, w_rs1_link;
  ras_op_e            w_ras_op;

  assign w_imm_i = {{(XPR_LEN-12){bus.inst_dx[31]}}, bus.inst_dx[31:20]};
  assign w_imm_b = {{(XPR_LEN-12){bus.inst_dx[31]}}, bus.inst_dx[7], bus.inst_dx[30:25],
                    bus.inst_dx[11:8], 1'b0};
  assign w_imm_j = {{(XPR_LEN-20){bus.inst_dx[31]}}, bus.inst_dx[19:12], bus.inst_dx[20],
                    bus.inst_dx[30:21], 1'b0};
  assign w_jalr_sum = bus.rs1_data + w_imm_i;

  always_comb begin
    w_mux_pc = r_pc_if + XPR_LEN'(4);
    case (bus.pc_src_sel)
      PcBranchTarget: w_mux_pc = bus.pc_dx + w_imm_b;
      PcJalTarget:    w_mux_pc = bus.pc_dx + w_imm_j;
      PcJalrTarget:   w_mux_pc = {w_jalr_sum[XPR_LEN-1:1], 1'b0};
      PcReplay:       w_mux_pc = r_pc_if;
      PcHandler:      w_mux_pc = bus.handler_pc;
      PcEpc:          w_mux_pc = bus.epc;
      PcRasPred:      w_mux_pc = w_ras_top;
      default:        w_mux_pc = r_pc_if + XPR_LEN'(4);
    endcase
  end

  assign w_redirect = !(bus.pc_src_sel inside {PcPlusFour, PcReplay});
  // A fresh redirect beats a held one; otherwise the held target beats the sequential PC.
  assign w_pc_pif   = w_redirect ? w_mux_pc : (r_pending ? r_pend_pc : w_mux_pc);

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_pc_if   <= RESET_PC;
      r_pend_pc <= '0;
      r_pending <= 1'b0;
    end else if (bus.stall_if) begin
      if (w_redirect) begin
        r_pend_pc <= w_mux_pc;
        r_pending <= 1'b1;
      end
    end else begin
      r_pc_if   <= w_pc_pif;
      r_pending <= 1'b0;
    end
  end

  assign w_opcode   = bus.inst_dx[6:0];
  assign w_rd       = bus.inst_dx[11:7];
  assign w_rs1      = bus.inst_dx[19:15];
  assign w_rd_link  = is_link(w_rd);
  assign w_rs1_link = is_link(w_rs1);

  always_comb begin
    w_ras_op = RasNone;
    if (bus.ras_update_en) begin
      if (w_opcode == OPCODE_JAL) begin
        if (w_rd_link) w_ras_op = RasPush;
      end else if (w_opcode == OPCODE_JALR) begin
        if (w_rd_link && !w_rs1_link)      w_ras_op = RasPush;
        else if (!w_rd_link && w_rs1_link) w_ras_op = RasPop;
        else if (w_rd_link && w_rs1_link)  w_ras_op = (w_rd != w_rs1) ? RasReplace : RasPush;
      end
    end
  end

  vscale_ras #(
    .XPR_LEN   (XPR_LEN),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .i_clk       (i_clk),
    .i_reset_n   (i_reset_n),
    .i_op        (w_ras_op),
    .i_push_data (bus.pc_dx + XPR_LEN'(4)),
    .o_top       (w_ras_top),
    .o_valid     (bus.ras_valid),
    .o_underflow (bus.ras_underflow)
  );

  assign bus.pc_pif            = w_pc_pif;
  assign bus.pc_if             = r_pc_if;
  assign bus.redirect_pending  = r_pending;
  assign bus.target_misaligned = (IALIGN == 32) && w_pc_pif[1];
  assign bus.ras_top           = w_ras_top;

endmodule

// File: tb/tb_vscale_pc_gen.sv
// Self-checking bench for vscale_pc_gen: IALIGN=32 main instance plus an IALIGN=16 twin.
module tb_vscale_pc_gen;
  import vscale_pc_gen_pkg::*;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  vscale_pc_gen_if #(.XPR_LEN(32)) bus ();
  vscale_pc_gen_if #(.XPR_LEN(32)) bus16 ();

  assign bus16.stall_if      = bus.stall_if;
  assign bus16.pc_src_sel    = bus.pc_src_sel;
  assign bus16.inst_dx       = bus.inst_dx;
  assign bus16.ras_update_en = bus.ras_update_en;
  assign bus16.rs1_data      = bus.rs1_data;
  assign bus16.pc_dx         = bus.pc_dx;
  assign bus16.handler_pc    = bus.handler_pc;
  assign bus16.epc           = bus.epc;

  vscale_pc_gen #(.XPR_LEN(32), .RESET_PC(32'h200), .RAS_DEPTH(4), .IALIGN(32)) dut (
    .i_clk     (clk),
    .i_reset_n (reset_n),
    .bus       (bus)
  );

  vscale_pc_gen #(.XPR_LEN(32), .RESET_PC(32'h200), .RAS_DEPTH(4), .IALIGN(16)) dut16 (
    .i_clk     (clk),
    .i_reset_n (reset_n),
    .bus       (bus16)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] top;
    logic        valid;
    logic        uf;
  } ras_exp_t;

  ras_exp_t    ras_q[$];
  logic [31:0] pc_q[$];

  function automatic logic [31:0] enc_jal(input logic [4:0] rd, input logic [20:0] imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  function automatic logic [31:0] enc_jalr(input logic [4:0] rd, input logic [4:0] rs1,
                                           input logic [11:0] imm);
    return {imm, rs1, 3'b000, rd, 7'b1100111};
  endfunction

  function automatic logic [31:0] enc_br(input logic [12:0] imm);
    return {imm[12], imm[10:5], 5'd0, 5'd0, 3'b000, imm[4:1], imm[11], 7'b1100011};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.stall_if      = 1'b0;
    bus.pc_src_sel    = PcPlusFour;
    bus.inst_dx       = 32'h0000_0013;
    bus.ras_update_en = 1'b0;
    bus.rs1_data      = '0;
    bus.pc_dx         = '0;
    bus.handler_pc    = '0;
    bus.epc           = '0;
  endtask

  task automatic test_reset();
    logic [31:0] exp_pc;
    idle_inputs();
    reset_n = 1'b0;
    step();
    step();
    checks++; if (bus.pc_if !== 32'h200) begin
      errors++; $display("FAIL reset_pc_if got=%h exp=%h", bus.pc_if, 32'h200);
    end
    checks++; if (bus.redirect_pending !== 1'b0) begin
      errors++; $display("FAIL reset_pending got=%b exp=0", bus.redirect_pending);
    end
    checks++; if (bus.ras_valid !== 1'b0 || bus.ras_top !== 32'h0 || bus.ras_underflow !== 1'b0)
    begin
      errors++; $display("FAIL reset_ras got valid=%b top=%h uf=%b exp 0/0/0",
                         bus.ras_valid, bus.ras_top, bus.ras_underflow);
    end
    reset_n = 1'b1;
    pc_q.push_back(32'h204); pc_q.push_back(32'h208); pc_q.push_back(32'h20C);
    repeat (3) begin
      step();
      exp_pc = pc_q.pop_front();
      checks++; if (bus.pc_if !== exp_pc) begin
        errors++; $display("FAIL free_run_pc_if got=%h exp=%h", bus.pc_if, exp_pc);
      end
    end
  endtask

  task automatic test_stall_redirect();
    logic [31:0] exp_pc;
    bus.stall_if   = 1'b1;
    bus.pc_src_sel = PcJalTarget;
    bus.pc_dx      = 32'h100;
    bus.inst_dx    = enc_jal(5'd0, 21'h40);
    #1;
    checks++; if (bus.pc_pif !== 32'h140) begin
      errors++; $display("FAIL jal_pc_pif got=%h exp=%h", bus.pc_pif, 32'h140);
    end
    step();
    checks++; if (bus.redirect_pending !== 1'b1 || bus.pc_if !== 32'h20C) begin
      errors++; $display("FAIL stall_hold got pend=%b pc_if=%h exp 1/%h",
                         bus.redirect_pending, bus.pc_if, 32'h20C);
    end
    bus.pc_src_sel = PcPlusFour;
    #1;
    checks++; if (bus.pc_pif !== 32'h140) begin
      errors++; $display("FAIL held_pc_pif got=%h exp=%h", bus.pc_pif, 32'h140);
    end
    bus.stall_if = 1'b0;
    pc_q.push_back(32'h140);
    step();
    exp_pc = pc_q.pop_front();
    checks++; if (bus.pc_if !== exp_pc || bus.redirect_pending !== 1'b0) begin
      errors++; $display("FAIL release_jal got pc_if=%h pend=%b exp %h/0",
                         bus.pc_if, bus.redirect_pending, exp_pc);
    end

    // Younger HANDLER redirect overwrites the held JAL target.
    bus.stall_if   = 1'b1;
    bus.pc_src_sel = PcJalTarget;
    step();
    bus.pc_src_sel = PcHandler;
    bus.handler_pc = 32'h300;
    step();
    checks++; if (bus.redirect_pending !== 1'b1 || bus.pc_if !== 32'h140) begin
      errors++; $display("FAIL handler_hold got pend=%b pc_if=%h exp 1/%h",
                         bus.redirect_pending, bus.pc_if, 32'h140);
    end
    bus.pc_src_sel = PcPlusFour;
    bus.stall_if   = 1'b0;
    pc_q.push_back(32'h300);
    step();
    exp_pc = pc_q.pop_front();
    checks++; if (bus.pc_if !== exp_pc) begin
      errors++; $display("FAIL release_handler got=%h exp=%h", bus.pc_if, exp_pc);
    end

    // Redirect arriving in the release cycle beats the held target.
    bus.stall_if   = 1'b1;
    bus.pc_src_sel = PcJalTarget;
    step();
    bus.stall_if   = 1'b0;
    bus.pc_src_sel = PcEpc;
    bus.epc        = 32'h400;
    pc_q.push_back(32'h400);
    step();
    exp_pc = pc_q.pop_front();
    checks++; if (bus.pc_if !== exp_pc || bus.redirect_pending !== 1'b0) begin
      errors++; $display("FAIL release_cycle_redirect got pc_if=%h pend=%b exp %h/0",
                         bus.pc_if, bus.redirect_pending, exp_pc);
    end
    bus.pc_src_sel = PcReplay;
    #1;
    checks++; if (bus.pc_pif !== 32'h400) begin
      errors++; $display("FAIL replay_pc_pif got=%h exp=%h", bus.pc_pif, 32'h400);
    end
    bus.pc_src_sel = PcPlusFour;
  endtask

  task automatic test_jalr_misalign();
    bus.pc_src_sel = PcJalrTarget;
    bus.rs1_data   = 32'h1001;
    bus.inst_dx    = enc_jalr(5'd0, 5'd2, 12'd2);
    #1;
    checks++; if (bus.pc_pif !== 32'h1002 || bus16.pc_pif !== 32'h1002) begin
      errors++; $display("FAIL jalr_pc_pif got=%h/%h exp=%h", bus.pc_pif, bus16.pc_pif,
                         32'h1002);
    end
    checks++; if (bus.target_misaligned !== 1'b1) begin
      errors++; $display("FAIL misaligned_ialign32 got=%b exp=1", bus.target_misaligned);
    end
    checks++; if (bus16.target_misaligned !== 1'b0) begin
      errors++; $display("FAIL misaligned_ialign16 got=%b exp=0", bus16.target_misaligned);
    end
    pc_q.push_back(32'h1002);
    step();
    checks++; if (bus.pc_if !== pc_q[0]) begin
      errors++; $display("FAIL jalr_pc_if got=%h exp=%h", bus.pc_if, pc_q[0]);
    end
    void'(pc_q.pop_front());
    bus.pc_src_sel = PcBranchTarget;
    bus.pc_dx      = 32'h100;
    bus.inst_dx    = enc_br(13'h1FF8);
    #1;
    checks++; if (bus.pc_pif !== 32'hF8 || bus.target_misaligned !== 1'b0) begin
      errors++; $display("FAIL branch_back got pc_pif=%h mis=%b exp %h/0",
                         bus.pc_pif, bus.target_misaligned, 32'hF8);
    end
    bus.pc_src_sel = PcPlusFour;
  endtask

  task automatic test_ras();
    ras_exp_t e;
    idle_inputs();
    bus.stall_if      = 1'b1;
    bus.ras_update_en = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      bus.pc_dx   = 32'(i * 16);
      bus.inst_dx = enc_jal(5'd1, 21'h8);
      ras_q.push_back('{top: 32'(i * 16 + 4), valid: 1'b1, uf: 1'b0});
      step();
      e = ras_q.pop_front();
      checks++; if (bus.ras_top !== e.top || bus.ras_valid !== e.valid) begin
        errors++; $display("FAIL ras_push%0d got top=%h valid=%b exp %h/%b",
                           i, bus.ras_top, bus.ras_valid, e.top, e.valid);
      end
    end
    ras_q.push_back('{top: 32'h44, valid: 1'b1, uf: 1'b0});
    ras_q.push_back('{top: 32'h34, valid: 1'b1, uf: 1'b0});
    ras_q.push_back('{top: 32'h24, valid: 1'b1, uf: 1'b0});
    bus.inst_dx = enc_jalr(5'd0, 5'd1, 12'd0);
    for (int j = 0; j < 3; j++) begin
      step();
      e = ras_q.pop_front();
      checks++; if (bus.ras_top !== e.top || bus.ras_valid !== e.valid) begin
        errors++; $display("FAIL ras_pop%0d got top=%h valid=%b exp %h/%b",
                           j, bus.ras_top, bus.ras_valid, e.top, e.valid);
      end
    end
    // Replace, then one pop must empty the stack (count unchanged at 1).
    bus.inst_dx = enc_jalr(5'd1, 5'd5, 12'd0);
    bus.pc_dx   = 32'h80;
    ras_q.push_back('{top: 32'h84, valid: 1'b1, uf: 1'b0});
    bus.ras_update_en = 1'b1;
    step();
    bus.ras_update_en = 1'b0;
    bus.pc_src_sel    = PcRasPred;
    #1;
    e = ras_q.pop_front();
    checks++; if (bus.ras_top !== e.top || bus.pc_pif !== e.top) begin
      errors++; $display("FAIL ras_replace got top=%h pc_pif=%h exp %h",
                         bus.ras_top, bus.pc_pif, e.top);
    end
    bus.pc_src_sel    = PcPlusFour;
    bus.ras_update_en = 1'b1;
    bus.inst_dx       = enc_jalr(5'd0, 5'd5, 12'd0);
    ras_q.push_back('{top: 32'h0, valid: 1'b0, uf: 1'b0});
    ras_q.push_back('{top: 32'h0, valid: 1'b0, uf: 1'b1});
    for (int k = 0; k < 2; k++) begin
      step();
      e = ras_q.pop_front();
      checks++; if (bus.ras_top !== e.top || bus.ras_valid !== e.valid ||
                    bus.ras_underflow !== e.uf) begin
        errors++; $display("FAIL ras_drain%0d got top=%h valid=%b uf=%b exp %h/%b/%b", k,
                           bus.ras_top, bus.ras_valid, bus.ras_underflow, e.top, e.valid, e.uf);
      end
    end
    // Gated JAL x1: no push, and the underflow pulse must drop.
    bus.ras_update_en = 1'b0;
    bus.inst_dx       = enc_jal(5'd1, 21'h8);
    step();
    checks++; if (bus.ras_valid !== 1'b0 || bus.ras_underflow !== 1'b0) begin
      errors++; $display("FAIL ras_gated got valid=%b uf=%b exp 0/0",
                         bus.ras_valid, bus.ras_underflow);
    end
    bus.ras_update_en = 1'b1;
    bus.inst_dx       = enc_jalr(5'd5, 5'd1, 12'd0);
    bus.pc_dx         = 32'h90;
    step();
    checks++; if (bus.ras_top !== 32'h94 || bus.ras_valid !== 1'b1) begin
      errors++; $display("FAIL ras_replace_empty got top=%h valid=%b exp %h/1",
                         bus.ras_top, bus.ras_valid, 32'h94);
    end
    bus.inst_dx = enc_jalr(5'd0, 5'd1, 12'd0);
    step();
    checks++; if (bus.ras_valid !== 1'b0) begin
      errors++; $display("FAIL ras_replace_empty_pop got valid=%b exp 0", bus.ras_valid);
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid_stall();
    idle_inputs();
    bus.stall_if      = 1'b1;
    bus.pc_src_sel    = PcJalTarget;
    bus.pc_dx         = 32'h100;
    bus.inst_dx       = enc_jal(5'd1, 21'h40);
    bus.ras_update_en = 1'b1;
    step();
    checks++; if (bus.redirect_pending !== 1'b1 || bus.ras_top !== 32'h104) begin
      errors++; $display("FAIL stall_push got pend=%b top=%h exp 1/%h",
                         bus.redirect_pending, bus.ras_top, 32'h104);
    end
    bus.ras_update_en = 1'b0;
    bus.pc_src_sel    = PcPlusFour;
    reset_n           = 1'b0;
    step();
    checks++; if (bus.redirect_pending !== 1'b0 || bus.pc_if !== 32'h200 ||
                  bus.ras_valid !== 1'b0) begin
      errors++; $display("FAIL reset_mid_stall got pend=%b pc_if=%h valid=%b exp 0/%h/0",
                         bus.redirect_pending, bus.pc_if, bus.ras_valid, 32'h200);
    end
    reset_n       = 1'b1;
    bus.stall_if  = 1'b0;
    pc_q.push_back(32'h204);
    step();
    checks++; if (bus.pc_if !== pc_q[0]) begin
      errors++; $display("FAIL after_reset_pc_if got=%h exp=%h", bus.pc_if, pc_q[0]);
    end
    void'(pc_q.pop_front());
  endtask

  initial begin
    test_reset();
    test_stall_redirect();
    test_jalr_misalign();
    test_ras();
    test_reset_mid_stall();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
